// File: rtl/led_ltr_pkg.sv
// Shared definitions for the LED running-light block.
//   LED_W      : number of LEDs driven
//   LED_START  : pattern loaded at reset and on recovery (leftmost LED)
//   LED_END    : rightmost LED pattern
//   dir_t      : stepping direction of the lit LED
//   is_onehot  : true when exactly one bit of an LED pattern is set
package led_ltr_pkg;

    localparam int LED_W = 8;
    localparam logic [LED_W-1:0] LED_START = 8'h80;
    localparam logic [LED_W-1:0] LED_END   = 8'h01;

    typedef enum logic {RIGHTWARD, LEFTWARD} dir_t;

    // Clearing the lowest set bit leaves zero only for a single-bit value.
    function automatic logic is_onehot(input logic [LED_W-1:0] v);
        return (v != '0) && ((v & (v - LED_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/led_step_tick.sv
// Prescaler: counts 0..CLK_DIV-1 and flags the last cycle of each interval.
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-low; clears the count
//   step_tick : 1 in the cycle where count == CLK_DIV-1
// With CLK_DIV=1 the count is a single bit stuck at 0, so step_tick is always 1.
module led_step_tick #(
    parameter int unsigned CLK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic step_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        step_tick = (cnt_q == CNT_MAX);
        cnt_d     = step_tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_left_to_right.sv
// 8-LED running light: one LED lit, stepping from LED8[7] towards LED8[0]
// once every CLK_DIV clocks. LED8 comes straight from flops.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low; LED8 = 8'h80 while low
//   LED8  : LED drive, 1 = on, bit 7 leftmost
// Build option LTR_BOUNCE_EN: when defined the light ping-pongs between the
// ends (RIGHTWARD/LEFTWARD FSM) instead of wrapping from LED8[0] to LED8[7].
// Any non-one-hot pattern (e.g. a flipped flop) is replaced by 8'h80 at the
// next step, with the direction forced back to RIGHTWARD.
module led_left_to_right
    import led_ltr_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    output logic [LED_W-1:0] LED8
);

    logic             step_tick;
    logic [LED_W-1:0] led_q, led_d;

    led_step_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .step_tick (step_tick)
    );

`ifdef LTR_BOUNCE_EN
    dir_t dir_q, dir_d;

    always_comb begin
        led_d = led_q;
        dir_d = dir_q;
        if (step_tick) begin
            if (!is_onehot(led_q)) begin
                led_d = LED_START;
                dir_d = RIGHTWARD;
            end else if (dir_q == RIGHTWARD) begin
                // Rightmost LED gets a single step, then we turn back.
                if (led_q == LED_END) begin
                    led_d = LED_END << 1;
                    dir_d = LEFTWARD;
                end else begin
                    led_d = led_q >> 1;
                end
            end else begin
                if (led_q == LED_START) begin
                    led_d = LED_START >> 1;
                    dir_d = RIGHTWARD;
                end else begin
                    led_d = led_q << 1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q <= LED_START;
            dir_q <= RIGHTWARD;
        end else begin
            led_q <= led_d;
            dir_q <= dir_d;
        end
    end
`else
    // Wrap mode: direction is permanently RIGHTWARD, so no state is kept for it.
    always_comb begin
        led_d = led_q;
        if (step_tick) begin
            if (!is_onehot(led_q) || led_q == LED_END) led_d = LED_START;
            else                                        led_d = led_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) led_q <= LED_START;
        else        led_q <= led_d;
    end
`endif

    assign LED8 = led_q;

endmodule

// File: tb/tb_led_left_to_right.sv
module tb_led_left_to_right;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] led4, led1;

    int total = 0;
    int bad   = 0;

    logic [7:0] q4[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    led_left_to_right #(.CLK_DIV(4)) dut4 (.clk(clk), .reset(reset), .LED8(led4));
    led_left_to_right #(.CLK_DIV(1)) dut1 (.clk(clk), .reset(reset), .LED8(led1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference LED sequence, indexed by the number of steps taken since reset.
    function automatic logic [7:0] exp_led(input int step);
`ifdef LTR_BOUNCE_EN
        logic [7:0] tbl [14] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02,
                                 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
        return tbl[step % 14];
`else
        logic [7:0] tbl [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        return tbl[step % 8];
`endif
    endfunction

    // One-hot must hold on every sampled cycle outside reset.
    always @(negedge clk) begin
        if (reset) begin
            chk("onehot4", 32'($onehot(led4)), 32'd1);
            chk("onehot1", 32'($onehot(led1)), 32'd1);
        end
    end

    // Push expectations for the coming edge, then pop and compare after it.
    task automatic run_edges(input int n, input int k0, input string tag);
        for (int k = k0 + 1; k <= k0 + n; k++) begin
            q4.push_back(exp_led(k / 4));
            q1.push_back(exp_led(k));
            @(negedge clk);
            chk({tag, "_div4"}, 32'(led4), 32'(q4.pop_front()));
            chk({tag, "_div1"}, 32'(led1), 32'(q1.pop_front()));
        end
    endtask

    initial begin
        int k;
        bit found;

        // Held in reset: no movement, prescaler held at zero.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_led4", 32'(led4), 32'h80);
            chk("rst_led1", 32'(led1), 32'h80);
        end
        chk("rst_cnt", 32'(dut4.u_tick.cnt_q), 32'd0);

        // Release between edges; run several full periods (wrap / bounce turns).
        reset = 1'b1;
        run_edges(64, 0, "seq");

        // Advance to LED8==08 on the divide-by-4 instance, bounded.
        found = 1'b0;
        k = 64;
        for (int i = 0; i < 64 && !found; i++) begin
            if (led4 == 8'h08) found = 1'b1;
            else begin
                run_edges(1, k, "seek");
                k++;
            end
        end
        chk("seek_08", 32'(found), 32'd1);

        // Asynchronous reset mid-interval: effect visible before any edge.
        #2 reset = 1'b0;
        #1;
        chk("async_led4", 32'(led4), 32'h80);
        chk("async_led1", 32'(led1), 32'h80);
        chk("async_cnt",  32'(dut4.u_tick.cnt_q), 32'd0);

        // Release again; first step must again come on the 4th edge.
        @(negedge clk);
        chk("hold_led4", 32'(led4), 32'h80);
        reset = 1'b1;
        run_edges(20, 0, "rel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
